// File: rtl/tx_scheduler_pkg.sv
// Shared constants for the TX word scheduler: K-character codes and the
// scheduler state encoding.
package tx_scheduler_pkg;

    localparam logic [7:0] KComma = 8'hBC;
    localparam logic [7:0] KSof   = 8'hFB;
    localparam logic [7:0] KEof   = 8'hFD;
    localparam logic [7:0] KFill  = 8'h1C;

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StTrain   = 3'd1;
    localparam logic [2:0] StSof     = 3'd2;
    localparam logic [2:0] StPayload = 3'd3;
    localparam logic [2:0] StEof     = 3'd4;

endpackage

// File: rtl/tx_rr_arbiter.sv
// Two-requester round-robin arbiter; the last-grant register moves only when
// the scheduler accepts a grant, so arbitration is per packet.
module tx_rr_arbiter (
    input  logic       clk_bit,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic       gnt_valid,
    output logic       gnt_port
);

    logic last_q;

    always_comb begin
        gnt_valid = |req;
        if (req == 2'b11) begin
            gnt_port = ~last_q;
        end else begin
            gnt_port = req[1];
        end
    end

    // Reset to port 1 so port 0 wins the first tie.
    always_ff @(posedge clk_bit or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (accept && gnt_valid) begin
            last_q <= gnt_port;
        end
    end

endmodule

// File: rtl/tx_scheduler.sv
// Word scheduler feeding an 8b/10b transmitter: frames requester packets with
// SOF/EOF, fills underruns, runs PRBS training bursts and idles on COMMA.
module tx_scheduler import tx_scheduler_pkg::*; #(
    parameter int unsigned TRAIN_WORDS = 1024,
    parameter int unsigned MAX_LEN     = 256
) (
    input  logic       clk_bit,
    input  logic       rst_n,
    input  logic       nextword_enable,
    input  logic [7:0] p0_data,
    input  logic       p0_valid,
    input  logic       p0_last,
    output logic       p0_ready,
    input  logic [7:0] p1_data,
    input  logic       p1_valid,
    input  logic       p1_last,
    output logic       p1_ready,
    input  logic       train_req,
    output logic [7:0] d_out,
    output logic       k_out,
    output logic       prbs_on,
    output logic       busy,
    output logic       len_err
);

    localparam int unsigned ByteW  = $clog2(MAX_LEN + 1);
    localparam int unsigned TrainW = $clog2(TRAIN_WORDS + 1);
    localparam logic [ByteW-1:0]  ByteMax  = ByteW'(MAX_LEN);
    localparam logic [TrainW-1:0] TrainMax = TrainW'(TRAIN_WORDS);

    logic [2:0]        state_q, state_d;
    logic [7:0]        word_q, word_d;
    logic              k_q, k_d;
    logic              prbs_q, prbs_d;
    logic              len_err_q, len_err_d;
    logic              gnt_q, gnt_d;
    logic [ByteW-1:0]  byte_cnt_q, byte_cnt_d;
    logic [TrainW-1:0] train_cnt_q, train_cnt_d;

    logic       arb_valid, arb_port, accept, take;
    logic       sel_valid, sel_last;
    logic [7:0] sel_data;

    assign sel_valid = gnt_q ? p1_valid : p0_valid;
    assign sel_last  = gnt_q ? p1_last  : p0_last;
    assign sel_data  = gnt_q ? p1_data  : p0_data;

    assign take     = nextword_enable && (state_q == StPayload) && sel_valid;
    assign p0_ready = take && !gnt_q;
    assign p1_ready = take && gnt_q;

    // Training has priority, so a grant is only consumed when no train_req.
    assign accept = nextword_enable && (state_q == StIdle) && !train_req && arb_valid;

    tx_rr_arbiter u_arb (
        .clk_bit   (clk_bit),
        .rst_n     (rst_n),
        .req       ({p1_valid, p0_valid}),
        .accept    (accept),
        .gnt_valid (arb_valid),
        .gnt_port  (arb_port)
    );

    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        k_d         = k_q;
        prbs_d      = prbs_q;
        gnt_d       = gnt_q;
        byte_cnt_d  = byte_cnt_q;
        train_cnt_d = train_cnt_q;
        len_err_d   = 1'b0;
        if (nextword_enable) begin
            word_d = KComma;
            k_d    = 1'b1;
            prbs_d = 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (train_req) begin
                        state_d     = StTrain;
                        train_cnt_d = '0;
                    end else if (arb_valid) begin
                        state_d = StSof;
                        gnt_d   = arb_port;
                    end
                end
                StTrain: begin
                    prbs_d      = 1'b1;
                    train_cnt_d = train_cnt_q + 1'b1;
                    if (train_cnt_d == TrainMax) begin
                        state_d     = StIdle;
                        train_cnt_d = '0;
                    end
                end
                StSof: begin
                    word_d     = KSof;
                    state_d    = StPayload;
                    byte_cnt_d = '0;
                end
                StPayload: begin
                    if (sel_valid) begin
                        word_d     = sel_data;
                        k_d        = 1'b0;
                        byte_cnt_d = byte_cnt_q + 1'b1;
                        if (sel_last) begin
                            state_d = StEof;
                        end else if (byte_cnt_d == ByteMax) begin
                            state_d   = StEof;
                            len_err_d = 1'b1;
                        end
                    end else begin
                        word_d = KFill;
                    end
                end
                StEof: begin
                    word_d     = KEof;
                    state_d    = StIdle;
                    byte_cnt_d = '0;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk_bit or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            word_q      <= KComma;
            k_q         <= 1'b1;
            prbs_q      <= 1'b0;
            len_err_q   <= 1'b0;
            gnt_q       <= 1'b0;
            byte_cnt_q  <= '0;
            train_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            k_q         <= k_d;
            prbs_q      <= prbs_d;
            len_err_q   <= len_err_d;
            gnt_q       <= gnt_d;
            byte_cnt_q  <= byte_cnt_d;
            train_cnt_q <= train_cnt_d;
        end
    end

    assign d_out   = word_q;
    assign k_out   = k_q;
    assign prbs_on = prbs_q;
    assign len_err = len_err_q;
    assign busy    = (state_q != StIdle);

endmodule
